row_pair_filter: RTL and testbench

ROW_PAIR_FILTER -- requirements
Module: row_pair_filter

---
 rtl/row_pair_filter.sv | 161 ++++++++++++++++
 tb/tb_row_pair_filter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/row_pair_filter.sv
// Row-pair image filter: fetches consecutive row pairs from a dual-row shifter,
// keeps each pixel that has a set vertical or horizontal neighbour, and streams
// every filtered row into a result BRAM as 16 x 32-bit words.

module row_pair_filter_lane #(
  parameter int VEC_W = 32
) (
  input  logic [VEC_W-1:0] prev_i,
  input  logic [VEC_W+1:0] win_i,   // current row slice with one neighbour bit on each side
  output logic [VEC_W-1:0] out_o
);
  assign out_o = win_i[VEC_W:1] & (prev_i | win_i[VEC_W-1:0] | win_i[VEC_W+1:2]);
endmodule

module row_pair_filter #(
  parameter int LAST_ROW = 511
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_trig_rd,
  output logic         o_trig_shift,
  output logic         o_init_en,
  output logic [8:0]   o_row_num_init,
  output logic [8:0]   o_row_num_to_read,
  input  logic         i_rd_done,
  input  logic [511:0] i_1st_row_512b,
  input  logic [511:0] i_2nd_row_512b,
  output logic [12:0]  o_wr_addr,
  output logic [31:0]  o_wr_data,
  output logic         o_wr_en,
  output logic [18:0]  o_kept_cnt
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 32;
  localparam int ROW_W     = NUM_LANES * VEC_W;
  localparam logic [8:0] LAST_R = 9'(LAST_ROW);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_ACK, S_WAIT_REL, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  r_q, r_d;
  logic [8:0]  row_q, row_d;
  logic [3:0]  w_q, w_d;
  logic        first_q, first_d;
  logic [18:0] kept_q, kept_d;
  logic        buf_load;

  logic [NUM_LANES-1:0][VEC_W-1:0] prev_w, filt_w, buf_q;
  logic [ROW_W+1:0]                cur_ext;

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    popcnt32 = '0;
    for (int i = 0; i < 32; i++) popcnt32 = popcnt32 + 6'(v[i]);
  endfunction

  // While the first flag is set the init fetch holds row 0 in the first register
  // and there is no row above it.
  always_comb begin
    prev_w  = first_q ? '0 : i_1st_row_512b;
    cur_ext = {1'b0, (first_q ? i_1st_row_512b : i_2nd_row_512b), 1'b0};
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    row_pair_filter_lane #(.VEC_W(VEC_W)) u_lane (
      .prev_i (prev_w[k]),
      .win_i  (cur_ext[k*VEC_W +: VEC_W+2]),
      .out_o  (filt_w[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (buf_load) buf_q <= filt_w;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      row_q   <= '0;
      w_q     <= '0;
      first_q <= 1'b0;
      kept_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      row_q   <= row_d;
      w_q     <= w_d;
      first_q <= first_d;
      kept_q  <= kept_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    row_d    = row_q;
    w_d      = w_q;
    first_d  = first_q;
    kept_d   = kept_q;
    buf_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_REQ;
          kept_d  = '0;
          r_d     = 9'd1;
          first_d = 1'b1;
        end
      end
      S_REQ:      state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (i_rd_done) state_d = S_WAIT_REL;
      S_WAIT_REL: if (!i_rd_done) state_d = S_CALC;
      S_CALC: begin
        buf_load = 1'b1;
        row_d    = first_q ? 9'd0 : r_q;
        w_d      = '0;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        kept_d = kept_q + 19'(popcnt32(o_wr_data));
        w_d    = w_q + 4'd1;
        if (w_q == 4'd15) begin
          // Row 1 is already in the shifter after the init fetch, so go straight to CALC.
          if (first_q) begin
            first_d = 1'b0;
            state_d = S_CALC;
          end else if (r_q == LAST_R) begin
            state_d = S_DONE;
          end else begin
            r_d     = r_q + 9'd1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE:  if (!i_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic fetching;
  assign fetching = (state_q == S_REQ) || (state_q == S_WAIT_ACK);

  always_comb begin
    o_busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    o_done            = (state_q == S_DONE);
    o_trig_rd         = fetching;
    o_trig_shift      = 1'b0;
    o_init_en         = fetching & first_q;
    o_row_num_init    = '0;
    o_row_num_to_read = fetching ? r_q : '0;
    o_wr_en           = (state_q == S_WRITE);
    o_wr_addr         = {row_q, w_q};
    o_wr_data         = o_wr_en ? buf_q[w_q] : '0;
    o_kept_cnt        = kept_q;
  end
endmodule

// File: tb/tb_row_pair_filter.sv
// Bench for row_pair_filter: behavioural shifter plus a per-pixel reference
// image model; expected BRAM writes are queued and checked by a monitor.

module tb_row_pair_filter;
  localparam int LAST = 511;

  logic         clk = 1'b0;
  logic         i_rst, i_start, i_rd_done;
  logic         o_busy, o_done, o_trig_rd, o_trig_shift, o_init_en, o_wr_en;
  logic [8:0]   o_row_num_init, o_row_num_to_read;
  logic [511:0] row1, row2;
  logic [12:0]  o_wr_addr;
  logic [31:0]  o_wr_data;
  logic [18:0]  o_kept_cnt;

  always #5 clk = ~clk;

  row_pair_filter #(.LAST_ROW(LAST)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_trig_rd(o_trig_rd), .o_trig_shift(o_trig_shift),
    .o_init_en(o_init_en), .o_row_num_init(o_row_num_init), .o_row_num_to_read(o_row_num_to_read),
    .i_rd_done(i_rd_done), .i_1st_row_512b(row1), .i_2nd_row_512b(row2),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en), .o_kept_cnt(o_kept_cnt)
  );

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [511:0] img [0:LAST];
  int           checks = 0;
  int           errors = 0;
  int           hold_extra = 0;
  int           exp_fetch = 1;
  int           exp_kept = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode 0: zeros, 1: ones, 2: sparse patterns, 3: random
  task automatic fill(input int mode);
    for (int r = 0; r <= LAST; r++) begin
      img[r] = (mode == 1) ? {512{1'b1}} : '0;
      if (mode == 3)
        for (int w = 0; w < 16; w++) img[r][w*32 +: 32] = $urandom;
    end
    if (mode == 2) begin
      img[0][0]   = 1'b1;
      img[1][0]   = 1'b1;
      img[5][100] = 1'b1;
      img[5][101] = 1'b1;
      img[10][200] = 1'b1;
    end
  endtask

  // Pixel-by-pixel application of the filter rule over the whole image.
  task automatic build_expected();
    logic [511:0] prev, cur, o;
    logic l, rt;
    wr_t e;
    exp_q.delete();
    exp_kept = 0;
    for (int r = 0; r <= LAST; r++) begin
      prev = (r == 0) ? '0 : img[r-1];
      cur  = img[r];
      for (int i = 0; i < 512; i++) begin
        l    = (i > 0)   ? cur[(i > 0) ? i-1 : 0]     : 1'b0;
        rt   = (i < 511) ? cur[(i < 511) ? i+1 : 511] : 1'b0;
        o[i] = cur[i] & (prev[i] | l | rt);
      end
      for (int w = 0; w < 16; w++) begin
        e.addr = 13'(r*16 + w);
        e.data = o[w*32 +: 32];
        exp_q.push_back(e);
        exp_kept += $countones(e.data);
      end
    end
  endtask

  // Dual-row shifter model: random fetch latency, optional extra hold of rd_done.
  initial begin : shifter
    int lat;
    logic ie;
    logic [8:0] rn;
    i_rd_done = 1'b0;
    row1 = '0;
    row2 = '0;
    forever begin
      @(negedge clk);
      if (!i_rst && o_trig_rd) begin
        lat = $urandom_range(1, 3);
        ie  = o_init_en;
        rn  = o_row_num_to_read;
        chk("fetch_row", 64'(rn), 64'(exp_fetch));
        chk("fetch_init_en", 64'(ie), 64'(exp_fetch == 1));
        chk("row_num_init", 64'(o_row_num_init), 64'd0);
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          chk("trig_hold", {o_trig_rd, o_init_en, o_row_num_to_read}, {1'b1, ie, rn});
        end
        i_rd_done = 1'b1;
        if (ie) begin
          row1 = img[0];
          row2 = img[rn];
        end else begin
          row1 = row2;
          row2 = img[rn];
        end
        for (int i = 0; i <= hold_extra; i++) begin
          @(negedge clk);
          chk("no_trig_while_done", 64'(o_trig_rd), 64'd0);
        end
        i_rd_done = 1'b0;
        exp_fetch++;
      end
    end
  end

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=0x%0h data=0x%0h expected=none", o_wr_addr, o_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(o_wr_addr), 64'(e.addr));
          chk("wr_data", 64'(o_wr_data), 64'(e.data));
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy_done"}, {o_busy, o_done}, 2'b00);
    chk({tag, "_wr_en"}, 64'(o_wr_en), 64'd0);
    chk({tag, "_trig"}, {o_trig_rd, o_trig_shift, o_init_en}, 3'b000);
    chk({tag, "_row_num"}, 64'(o_row_num_to_read), 64'd0);
    chk({tag, "_kept"}, 64'(o_kept_cnt), 64'd0);
  endtask

  task automatic run_frame(input string tag, input int hold);
    bit done;
    build_expected();
    exp_fetch  = 1;
    hold_extra = hold;
    i_start    = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_after_start"}, {o_busy, o_trig_rd}, 2'b11);
    done = 1'b0;
    for (int n = 0; n < 30000 && !done; n++) begin
      @(negedge clk);
      if (o_done) done = 1'b1;
    end
    chk({tag, "_frame_done"}, 64'(done), 64'd1);
    chk({tag, "_kept_cnt"}, 64'(o_kept_cnt), 64'(exp_kept));
    chk({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_done_held"}, {o_done, o_busy, o_wr_en, o_trig_rd}, 4'b1000);
      chk({tag, "_kept_held"}, 64'(o_kept_cnt), 64'(exp_kept));
    end
    i_start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after_done"}, {o_done, o_busy}, 2'b00);
  endtask

  initial begin : main
    bit found;
    i_rst   = 1'b1;
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    i_rst = 1'b0;

    // Abort a frame in row 3, word 7, then restart cleanly.
    fill(3);
    build_expected();
    exp_fetch  = 1;
    hold_extra = 0;
    i_start    = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 5000 && !found; n++) begin
      @(negedge clk);
      if (o_wr_en && o_wr_addr == 13'd55) found = 1'b1;
    end
    chk("reached_row3_w7", 64'(found), 64'd1);
    i_rst   = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    i_rst = 1'b0;
    exp_q.delete();

    fill(0);
    run_frame("zeros", 0);
    fill(1);
    run_frame("ones", 0);
    chk("ones_kept_total", 64'(exp_kept), 64'd262144);
    fill(2);
    run_frame("sparse", 0);
    fill(3);
    run_frame("random_hold", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
